step_pulse_gen: RTL and testbench

//  Source side of the processor clocking path: turns the raw pushbutton and AUTO slide switch

---
 rtl/step_gen_pkg.sv | 25 ++
 rtl/input_debounce.sv | 46 ++++
 rtl/step_pulse_gen.sv | 102 ++++++++++
 tb/tb_step_pulse_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/step_gen_pkg.sv
// Shared types and width helpers for the step pulse generator.
// Counter widths are derived from the counts they must hold.
package step_gen_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;
  localparam int unsigned AUTO_DIV_DEF   = 50_000_000;

  // Bits needed for a counter running 0..n-1 (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(
    input int unsigned deb,
    input int unsigned div
  );
    return (deb >= 1) && (div >= 2);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stable-level debounce counter.
// tgl flags the edge on which clean takes the synchronized level.
module input_debounce
  import step_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic tgl
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    tgl   = 1'b0;
    if (sync2 != clean) begin
      if (cnt == LAST) tgl = 1'b1;
      else cnt_d = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt   <= cnt_d;
      clean <= clean ^ tgl;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Clean single-cycle STEP source: debounced manual button or
// periodic auto divider, selected by a debounced mode switch.
module step_pulse_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned AUTO_DIV        = AUTO_DIV_DEF,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_raw,
  input  logic             AUTO_raw,
  output logic             STEP,
  output logic             MODE_AUTO,
  output logic             BTN_clean,
  output logic [CNT_W-1:0] STEP_CNT
);

  localparam int unsigned DW = cnt_width(AUTO_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

  if (!params_ok(DEBOUNCE_CYCLES, AUTO_DIV)) begin : g_bad_params
    $error("step_pulse_gen: DEBOUNCE_CYCLES>=1, AUTO_DIV>=2");
  end

  logic          btn_tgl;
  logic          btn_d;
  logic          auto_clean;
  logic          auto_tgl;
  mode_t         mode;
  mode_t         mode_d;
  logic          btn_prev;
  logic          btn_prev_d;
  logic [DW-1:0] div;
  logic [DW-1:0] div_d;
  logic          step_d;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (CLK),
    .rst   (RST),
    .raw   (BTN_raw),
    .clean (BTN_clean),
    .tgl   (btn_tgl)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
    .clk   (CLK),
    .rst   (RST),
    .raw   (AUTO_raw),
    .clean (auto_clean),
    .tgl   (auto_tgl)
  );

  assign btn_d     = BTN_clean ^ btn_tgl;
  assign MODE_AUTO = (mode == step_gen_pkg::MODE_AUTO);

  always_comb begin
    mode_d = mode;
    unique case (mode)
      step_gen_pkg::MODE_MANUAL:
        if (auto_tgl && !auto_clean) mode_d = step_gen_pkg::MODE_AUTO;
      step_gen_pkg::MODE_AUTO:
        if (auto_tgl && auto_clean) mode_d = step_gen_pkg::MODE_MANUAL;
      default: mode_d = step_gen_pkg::MODE_MANUAL;
    endcase
  end

  // A mode-change edge swallows any button edge in flight.
  always_comb begin
    step_d     = 1'b0;
    div_d      = div;
    btn_prev_d = BTN_clean;
    if (mode_d != mode) begin
      div_d      = '0;
      btn_prev_d = btn_d;
    end else if (mode == step_gen_pkg::MODE_AUTO) begin
      step_d = (div == DIV_LAST);
      div_d  = step_d ? '0 : div + DW'(1);
    end else begin
      step_d = BTN_clean & ~btn_prev;
    end
    step_d = step_d & ~STEP;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode     <= step_gen_pkg::MODE_MANUAL;
      div      <= '0;
      btn_prev <= 1'b0;
      STEP     <= 1'b0;
      STEP_CNT <= '0;
    end else begin
      mode     <= mode_d;
      div      <= div_d;
      btn_prev <= btn_prev_d;
      STEP     <= step_d;
      STEP_CNT <= STEP_CNT + CNT_W'(step_d);
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: expected STEP cycles and
// counts are queued at stimulus time and matched by a monitor.
module tb_step_pulse_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_raw = 1'b0;
  logic       AUTO_raw = 1'b0;
  logic       STEP;
  logic       MODE_AUTO;
  logic       BTN_clean;
  logic [7:0] STEP_CNT;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_DIV       (5),
    .CNT_W          (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_raw  (BTN_raw),
    .AUTO_raw (AUTO_raw),
    .STEP     (STEP),
    .MODE_AUTO(MODE_AUTO),
    .BTN_clean(BTN_clean),
    .STEP_CNT (STEP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         c;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       step_q = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pulse(input int c);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{c: c, cnt: exp_cnt});
  endtask

  // Every STEP must match the queue head; no head may be skipped.
  always @(negedge CLK) begin
    if (RST) begin
      step_q = 1'b0;
    end else begin
      if (sb.size() != 0 && sb[0].c < cyc) begin
        n_cmp++;
        assert (sb[0].c >= cyc) else begin
          n_bad++;
          $error("FAIL missed_step observed=none expected_cyc=%0d",
                 sb[0].c);
        end
        void'(sb.pop_front());
      end
      if (STEP) begin
        mon_e.c   = -1;
        mon_e.cnt = 8'd0;
        if (sb.size() != 0 && sb[0].c == cyc) mon_e = sb.pop_front();
        n_cmp++;
        assert (cyc === mon_e.c && STEP_CNT === mon_e.cnt) else begin
          n_bad++;
          $error("FAIL step observed cyc=%0d cnt=%0d expected cyc=%0d cnt=%0d",
                 cyc, STEP_CNT, mon_e.c, mon_e.cnt);
        end
        n_cmp++;
        assert (step_q === 1'b0) else begin
          n_bad++;
          $error("FAIL step_double observed=1 expected=0 cyc=%0d", cyc);
        end
      end
      step_q = STEP;
    end
  end

  initial begin
    int l, a, s, w, r;

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      BTN_raw  = ~BTN_raw;
      AUTO_raw = ~AUTO_raw;
      tick(1);
      chk("rst_outs", {STEP, MODE_AUTO, BTN_clean, STEP_CNT}, 32'd0);
    end
    BTN_raw  = 1'b0;
    AUTO_raw = 1'b0;
    tick(1);
    RST = 1'b0;
    tick(10);
    chk("idle_outs", {STEP, MODE_AUTO, BTN_clean, STEP_CNT}, 32'd0);

    // Bouncing button, then held
    for (int i = 0; i < 10; i++) begin
      BTN_raw = ~BTN_raw;
      tick(2);
      chk("bounce_clean", BTN_clean, 32'd0);
    end
    BTN_raw = 1'b1;
    l = cyc;
    push_pulse(l + 7);
    tick(5);
    chk("btn_clean_pre", BTN_clean, 32'd0);
    tick(1);
    chk("btn_clean_rise", BTN_clean, 32'd1);
    tick(3);
    chk("cnt_after_press", STEP_CNT, 32'd1);

    // Held button, release, press again
    tick(100);
    BTN_raw = 1'b0;
    tick(10);
    chk("btn_clean_fall", BTN_clean, 32'd0);
    BTN_raw = 1'b1;
    push_pulse(cyc + 7);
    tick(10);
    chk("cnt_second_press", STEP_CNT, 32'd2);
    BTN_raw = 1'b0;
    tick(10);

    // Auto mode with a button press inside the window
    AUTO_raw = 1'b1;
    a = cyc;
    for (int j = 0; j < 6; j++) push_pulse(a + 11 + 5 * j);
    tick(5);
    chk("mode_pre_auto", MODE_AUTO, 32'd0);
    tick(1);
    chk("mode_auto", MODE_AUTO, 32'd1);
    BTN_raw = 1'b1;
    tick(12);
    BTN_raw = 1'b0;
    tick(20);
    push_pulse(a + 41);

    // Back to manual mid-count, button landing on the transition edge
    AUTO_raw = 1'b0;
    BTN_raw  = 1'b1;
    s = cyc;
    tick(5);
    chk("mode_pre_manual", MODE_AUTO, 32'd1);
    tick(1);
    chk("mode_manual", MODE_AUTO, 32'd0);
    chk("btn_on_transition", BTN_clean, 32'd1);
    tick(15);
    chk("cnt_no_transition_step", STEP_CNT, 32'd9);
    BTN_raw = 1'b0;
    tick(10);
    BTN_raw = 1'b1;
    push_pulse(cyc + 7);
    tick(10);
    chk("cnt_fresh_press", STEP_CNT, 32'd10);
    BTN_raw = 1'b0;
    tick(10);

    // Long auto run through the counter wrap, then reset mid-period
    AUTO_raw = 1'b1;
    w = cyc;
    for (int j = 0; j < 249; j++) push_pulse(w + 11 + 5 * j);
    tick(1253);
    chk("cnt_wrapped", STEP_CNT, 32'd3);
    RST = 1'b1;
    #1;
    chk("rst_mid_outs", {STEP, MODE_AUTO, BTN_clean, STEP_CNT}, 32'd0);
    tick(2);
    RST = 1'b0;
    r = cyc;
    exp_cnt = 8'd0;
    push_pulse(r + 11);
    push_pulse(r + 16);
    tick(5);
    chk("mode_after_rst_pre", MODE_AUTO, 32'd0);
    tick(1);
    chk("mode_after_rst", MODE_AUTO, 32'd1);
    tick(12);
    chk("cnt_after_rst", STEP_CNT, 32'd2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
